pipelined_instr_decoder: RTL and testbench

PIPELINED_INSTR_DECODER -- requirements
Module: pipelined_instr_decoder

---
 rtl/cpu_isa_pkg.sv | 60 ++++++
 rtl/instr_fifo.sv | 46 ++++
 rtl/pipelined_instr_decoder.sv | 142 ++++++++++++++
 tb/tb_pipelined_instr_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants, family codes and the decoded-instruction record shared by
// the decoder and its helpers.
package cpu_isa_pkg;

  localparam int INSTR_W = 16;
  localparam int IMM_W   = 16;

  localparam logic [3:0] OPC_RTYPE   = 4'h0;
  localparam logic [3:0] OPC_ANDI    = 4'h1;
  localparam logic [3:0] OPC_ORI     = 4'h2;
  localparam logic [3:0] OPC_XORI    = 4'h3;
  localparam logic [3:0] OPC_SPECIAL = 4'h4;
  localparam logic [3:0] OPC_SHIFT   = 4'h8;
  localparam logic [3:0] OPC_BCOND   = 4'hC;
  localparam logic [3:0] OPC_LUI     = 4'hF;

  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;
  localparam logic [3:0] EXT_RSH   = 4'hF;
  localparam logic [3:0] EXT_LSH   = 4'h4;
  localparam logic [3:0] EXT_ASH   = 4'h6;

  typedef enum logic [2:0] {
    FAM_R, FAM_SPECIAL, FAM_SHIFT, FAM_BCOND, FAM_ITYPE
  } fam_e;

  // imm_sx selects how the 16-bit immediate is widened to the datapath.
  typedef struct packed {
    logic [7:0]       op;
    logic [3:0]       rdest;
    logic [3:0]       rsrc;
    logic [IMM_W-1:0] imm;
    logic             imm_sx;
    logic             r_or_i;
    logic             is_branch;
    logic             is_mem;
    logic             illegal;
  } dec_t;

  function automatic fam_e family_of(input logic [3:0] opc);
    case (opc)
      OPC_RTYPE:   return FAM_R;
      OPC_SPECIAL: return FAM_SPECIAL;
      OPC_SHIFT:   return FAM_SHIFT;
      OPC_BCOND:   return FAM_BCOND;
      default:     return FAM_ITYPE;
    endcase
  endfunction

  function automatic logic r_ext_legal(input logic [3:0] ext);
    case (ext)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
      4'h9, 4'hA, 4'hB, 4'hD, 4'hE: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer; flush and reset both empty it in one edge.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          wr_en, rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/pipelined_instr_decoder.sv
// Fetch FIFO feeding a single decoded-instruction output register with
// valid/ready handshake; decode is combinational on the FIFO head.
module pipelined_instr_decoder
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 4,
  parameter bit ZEXT_LOGICAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [15:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [7:0]               op,
  output logic [3:0]               rdest,
  output logic [3:0]               rsrc,
  output logic [DATA_W-1:0]        imm,
  output logic                     r_or_i,
  output logic                     is_branch,
  output logic                     is_mem,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0] head;
  logic        full, empty, push, pop;
  dec_t        d;

  function automatic dec_t decode(input logic [15:0] w);
    dec_t r;
    r = '0;
    r.op[7:4] = w[15:12];
    case (family_of(w[15:12]))
      FAM_R: begin
        r.op[3:0] = w[7:4];
        r.rdest   = w[11:8];
        r.rsrc    = w[3:0];
        r.r_or_i  = 1'b1;
        r.illegal = !r_ext_legal(w[7:4]);
      end
      FAM_SPECIAL: begin
        r.op[3:0] = w[7:4];
        r.rdest   = w[11:8];
        r.rsrc    = w[3:0];
        r.r_or_i  = 1'b1;
        case (w[7:4])
          EXT_LOAD, EXT_STOR: r.is_mem    = 1'b1;
          EXT_JAL, EXT_JCOND: r.is_branch = 1'b1;
          EXT_RSH:            ;
          default:            r.illegal   = 1'b1;
        endcase
      end
      FAM_SHIFT: begin
        r.op[3:0] = w[7:4];
        r.rdest   = w[11:8];
        if (w[7:4] == EXT_LSH || w[7:4] == EXT_ASH) begin
          r.rsrc   = w[3:0];
          r.r_or_i = 1'b1;
        end else if (w[7:6] == 2'b00) begin
          // LSHI/ASHUI: 5-bit signed shift amount
          r.imm    = {{11{w[4]}}, w[4:0]};
          r.imm_sx = 1'b1;
        end else begin
          r.rsrc    = w[3:0];
          r.r_or_i  = 1'b1;
          r.illegal = 1'b1;
        end
      end
      FAM_BCOND: begin
        r.op[3:0]   = w[11:8];
        r.is_branch = 1'b1;
        r.imm       = {{8{w[7]}}, w[7:0]};
        r.imm_sx    = 1'b1;
      end
      default: begin
        r.rdest = w[11:8];
        if (w[15:12] == OPC_LUI) begin
          r.imm = {w[7:0], 8'h00};
        end else if (ZEXT_LOGICAL && (w[15:12] == OPC_ANDI ||
                     w[15:12] == OPC_ORI || w[15:12] == OPC_XORI)) begin
          r.imm = {8'h00, w[7:0]};
        end else begin
          r.imm    = {{8{w[7]}}, w[7:0]};
          r.imm_sx = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  assign instr_ready = (fifo_count < CW'(DEPTH));
  assign push        = instr_valid && instr_ready;
  assign pop         = !empty && (!dec_valid || dec_ready);
  assign d           = decode(head);

  instr_fifo #(.DEPTH(DEPTH), .W(16), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (instr),
    .head  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid <= 1'b0;
      op        <= '0;
      rdest     <= '0;
      rsrc      <= '0;
      imm       <= '0;
      r_or_i    <= 1'b0;
      is_branch <= 1'b0;
      is_mem    <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (pop) begin
      dec_valid <= 1'b1;
      op        <= d.op;
      rdest     <= d.rdest;
      rsrc      <= d.rsrc;
      imm       <= d.imm_sx ? DATA_W'($signed(d.imm)) : DATA_W'(d.imm);
      r_or_i    <= d.r_or_i;
      is_branch <= d.is_branch;
      is_mem    <= d.is_mem;
      illegal   <= d.illegal;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Directed checks: decode table, latency, backpressure, flush and reset.
module tb_pipelined_instr_decoder;

  logic        clk = 1'b0;
  logic        reset, flush, instr_valid, dec_ready;
  logic [15:0] instr;
  logic        instr_ready, dec_valid;
  logic [7:0]  op;
  logic [3:0]  rdest, rsrc;
  logic [15:0] imm;
  logic        r_or_i, is_branch, is_mem, illegal;
  logic [2:0]  fifo_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_instr_decoder #(.DATA_W(16), .DEPTH(4), .ZEXT_LOGICAL(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .op(op), .rdest(rdest),
    .rsrc(rsrc), .imm(imm), .r_or_i(r_or_i), .is_branch(is_branch),
    .is_mem(is_mem), .illegal(illegal), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  op;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        r_or_i;
    logic        br;
    logic        mem;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fields(input string tag, input vec_t v);
    chk({tag, ".op"},     32'(op),        32'(v.op));
    chk({tag, ".rdest"},  32'(rdest),     32'(v.rdest));
    chk({tag, ".rsrc"},   32'(rsrc),      32'(v.rsrc));
    chk({tag, ".imm"},    32'(imm),       32'(v.imm));
    chk({tag, ".r_or_i"}, 32'(r_or_i),    32'(v.r_or_i));
    chk({tag, ".branch"}, 32'(is_branch), 32'(v.br));
    chk({tag, ".mem"},    32'(is_mem),    32'(v.mem));
    chk({tag, ".ill"},    32'(illegal),   32'(v.ill));
  endtask

  // Push one word into an empty pipe, check latency and decode, then consume it.
  task automatic send_and_check(input vec_t v);
    instr = v.instr; instr_valid = 1'b1; dec_ready = 1'b0;
    step();
    instr_valid = 1'b0;
    chk($sformatf("lat1_%h", v.instr), 32'(dec_valid), 32'd0);
    step();
    chk($sformatf("lat2_%h", v.instr), 32'(dec_valid), 32'd1);
    chk_fields($sformatf("v%h", v.instr), v);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk($sformatf("drain_%h", v.instr), 32'(dec_valid), 32'd0);
  endtask

  initial begin
    int acc;
    vec_t v;
    vecs[0]  = '{16'h0151, 8'h05, 4'h1, 4'h1, 16'h0000, 1, 0, 0, 0};
    vecs[1]  = '{16'h51FF, 8'h50, 4'h1, 4'h0, 16'hFFFF, 0, 0, 0, 0};
    vecs[2]  = '{16'h12F0, 8'h10, 4'h2, 4'h0, 16'h00F0, 0, 0, 0, 0};
    vecs[3]  = '{16'hC1FE, 8'hC1, 4'h0, 4'h0, 16'hFFFE, 0, 1, 0, 0};
    vecs[4]  = '{16'h0F4F, 8'h04, 4'hF, 4'hF, 16'h0000, 1, 0, 0, 1};
    vecs[5]  = '{16'h4302, 8'h40, 4'h3, 4'h2, 16'h0000, 1, 0, 1, 0};
    vecs[6]  = '{16'h45C7, 8'h4C, 4'h5, 4'h7, 16'h0000, 1, 1, 0, 0};
    vecs[7]  = '{16'h4A3B, 8'h43, 4'hA, 4'hB, 16'h0000, 1, 0, 0, 1};
    vecs[8]  = '{16'h8314, 8'h81, 4'h3, 4'h0, 16'hFFF4, 0, 0, 0, 0};
    vecs[9]  = '{16'h8769, 8'h86, 4'h7, 4'h9, 16'h0000, 1, 0, 0, 0};
    vecs[10] = '{16'hF2AB, 8'hF0, 4'h2, 4'h0, 16'hAB00, 0, 0, 0, 0};
    vecs[11] = '{16'h9480, 8'h90, 4'h4, 4'h0, 16'hFF80, 0, 0, 0, 0};
    vecs[12] = '{16'h3680, 8'h30, 4'h6, 4'h0, 16'h0080, 0, 0, 0, 0};
    vecs[13] = '{16'h8590, 8'h89, 4'h5, 4'h0, 16'h0000, 1, 0, 0, 1};
    vecs[14] = '{16'h802F, 8'h82, 4'h0, 4'h0, 16'h000F, 0, 0, 0, 0};

    reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0; instr = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst.valid", 32'(dec_valid), 32'd0);
    chk("rst.count", 32'(fifo_count), 32'd0);
    chk("rst.ready", 32'(instr_ready), 32'd1);
    chk("rst.op",    32'(op), 32'd0);
    chk("rst.imm",   32'(imm), 32'd0);

    foreach (vecs[i]) send_and_check(vecs[i]);

    // Backpressure: 5 accepts fill output register plus 4 FIFO entries.
    acc = 0;
    dec_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      instr = 16'h1000 + 16'(acc + 1); instr_valid = 1'b1;
      if (instr_ready) acc++;
      step();
    end
    chk("bp.accepts", 32'(acc), 32'd5);
    chk("bp.ready",   32'(instr_ready), 32'd0);
    chk("bp.count",   32'(fifo_count), 32'd4);
    chk("bp.valid",   32'(dec_valid), 32'd1);
    chk("bp.imm",     32'(imm), 32'h0001);
    step();
    chk("bp.hold_imm", 32'(imm), 32'h0001);
    chk("bp.hold_op",  32'(op), 32'h10);
    instr = 16'h1006; dec_ready = 1'b1;
    step();
    chk("bp.pop_only_count", 32'(fifo_count), 32'd3);
    chk("bp.pop_imm",        32'(imm), 32'h0002);
    step();
    chk("bp.pushpop_count", 32'(fifo_count), 32'd3);
    chk("bp.pushpop_imm",   32'(imm), 32'h0003);
    instr_valid = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      step();
      chk($sformatf("bp.drain%0d", k), 32'(imm), 32'(k));
    end
    step();
    chk("bp.empty_valid", 32'(dec_valid), 32'd0);
    dec_ready = 1'b0;

    // Flush with 3 buffered entries and a concurrent push.
    for (int i = 1; i <= 4; i++) begin
      instr = 16'h2000 + 16'(i); instr_valid = 1'b1;
      step();
    end
    chk("fl.pre_count", 32'(fifo_count), 32'd3);
    chk("fl.pre_valid", 32'(dec_valid), 32'd1);
    instr = 16'h2FFF; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid = 1'b0;
    chk("fl.count", 32'(fifo_count), 32'd0);
    chk("fl.valid", 32'(dec_valid), 32'd0);
    dec_ready = 1'b1;
    step(); step();
    chk("fl.no_emerge", 32'(dec_valid), 32'd0);
    dec_ready = 1'b0;
    v = '{16'h2345, 8'h20, 4'h3, 4'h0, 16'h0045, 0, 0, 0, 0};
    send_and_check(v);

    // Reset mid-operation dominates flush and push.
    for (int i = 1; i <= 3; i++) begin
      instr = 16'hC1FE; instr_valid = 1'b1;
      step();
    end
    chk("rs.pre_count", 32'(fifo_count), 32'd2);
    chk("rs.pre_valid", 32'(dec_valid), 32'd1);
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; instr_valid = 1'b0;
    chk("rs.count",  32'(fifo_count), 32'd0);
    chk("rs.valid",  32'(dec_valid), 32'd0);
    chk("rs.op",     32'(op), 32'd0);
    chk("rs.imm",    32'(imm), 32'd0);
    chk("rs.branch", 32'(is_branch), 32'd0);
    chk("rs.ready",  32'(instr_ready), 32'd1);
    send_and_check(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
